// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, block type, key-expander state encoding,
// and the byte-level helpers (GF(2^8) arithmetic, S-box, round constant)
// used by the combinational key schedule.
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_RK_AW      = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } key_exp_state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box: inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load / round-key read bus between the AES datapath (master) and the
// key expander (slave).
//   key_valid_in/key_ready_out/key_in : cipher-key handshake
//   clear_in                          : synchronous invalidate
//   busy_out, keys_valid_out          : expansion status
//   rk_addr_in/rk_data_out            : registered round-key read port
interface aes_key_expander_if;
    import aes_pkg::*;

    logic                 clear_in;
    logic                 key_valid_in;
    logic                 key_ready_out;
    aes_block_t           key_in;
    logic                 busy_out;
    logic                 keys_valid_out;
    logic [AES_RK_AW-1:0] rk_addr_in;
    aes_block_t           rk_data_out;

    modport master (
        output clear_in, key_valid_in, key_in, rk_addr_in,
        input  key_ready_out, busy_out, keys_valid_out, rk_data_out
    );

    modport slave (
        input  clear_in, key_valid_in, key_in, rk_addr_in,
        output key_ready_out, busy_out, keys_valid_out, rk_data_out
    );

endinterface

// File: rtl/aes_key_schedule.sv
// One combinational AES-128 key-schedule round.
//   round_in : round number 1..10 (selects Rcon)
//   key_in   : previous round key, row-major state layout
//   key_out  : next round key, same layout
// Row-major: bits [127:96] are row 0, bytes within a row in column order.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic [AES_RK_AW-1:0] round_in,
    input  aes_block_t           key_in,
    output aes_block_t           key_out
);

    logic [7:0] w_kin  [4][4];
    logic [7:0] w_kout [4][4];
    logic [7:0] w_temp [4];

    always_comb begin
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                w_kin[r][c] = key_in[127 - 8*(4*r + c) -: 8];
            end
        end
        // RotWord+SubWord on the last column; row r takes row r+1's byte.
        for (int unsigned r = 0; r < 4; r++) begin
            w_temp[r] = sbox(w_kin[(r + 1) % 4][3]) ^ ((r == 0) ? rcon(round_in) : 8'h00);
        end
        for (int unsigned r = 0; r < 4; r++) begin
            w_kout[r][0] = w_kin[r][0] ^ w_temp[r];
            for (int unsigned c = 1; c < 4; c++) begin
                w_kout[r][c] = w_kout[r][c-1] ^ w_kin[r][c];
            end
        end
        key_out = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                key_out[127 - 8*(4*r + c) -: 8] = w_kout[r][c];
            end
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expander: accepts a cipher key, steps aes_key_schedule over
// rounds 1..NUM_ROUNDS, stores all round keys, serves them via a 1-cycle
// registered read port.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : aes_key_expander_if slave (handshake, clear, status, read port)
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int RK_AW      = AES_RK_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_expander_if.slave    bus
);

    localparam logic [RK_AW-1:0] LP_LAST = RK_AW'(NUM_ROUNDS);

    key_exp_state_t   r_state;
    key_exp_state_t   w_next_state;
    logic [RK_AW-1:0] r_cnt;
    logic [KEY_W-1:0] r_work;
    logic [KEY_W-1:0] r_rk [0:NUM_ROUNDS];
    logic             r_keys_valid;
    logic [KEY_W-1:0] r_rk_data;
    logic [KEY_W-1:0] w_sched;
    logic             w_key_ready;
    logic             w_busy;
    logic             w_accept;

    aes_key_schedule u_sched (
        .round_in (r_cnt),
        .key_in   (r_work),
        .key_out  (w_sched)
    );

    // clear_in wins over a simultaneous offer, so the key is never taken.
    assign w_accept = bus.key_valid_in && w_key_ready && !bus.clear_in;

    always_comb begin
        w_next_state = r_state;
        w_key_ready  = 1'b1;
        w_busy       = 1'b0;
        case (r_state)
            IDLE, READY: begin
                if (w_accept) w_next_state = EXPAND;
            end
            EXPAND: begin
                w_key_ready = 1'b0;
                w_busy      = 1'b1;
                if (r_cnt == LP_LAST) w_next_state = READY;
            end
            default: w_next_state = IDLE;
        endcase
        if (bus.clear_in) w_next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_work       <= '0;
            r_keys_valid <= 1'b0;
            r_rk_data    <= '0;
            for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (bus.clear_in) begin
                r_cnt        <= '0;
                r_keys_valid <= 1'b0;
            end else if (w_accept) begin
                r_rk[0]      <= bus.key_in;
                r_work       <= bus.key_in;
                r_cnt        <= RK_AW'(1);
                r_keys_valid <= 1'b0;
            end else if (r_state == EXPAND) begin
                r_rk[r_cnt] <= w_sched;
                r_work      <= w_sched;
                if (r_cnt == LP_LAST) begin
                    r_cnt        <= '0;
                    r_keys_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + RK_AW'(1);
                end
            end
            // Reads see pre-edge contents: no write-to-read bypass.
            r_rk_data <= (bus.rk_addr_in <= LP_LAST) ? r_rk[bus.rk_addr_in] : '0;
        end
    end

    assign bus.key_ready_out  = w_key_ready;
    assign bus.busy_out       = w_busy;
    assign bus.keys_valid_out = r_keys_valid;
    assign bus.rk_data_out    = r_rk_data;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed self-checking bench for aes_key_expander using FIPS-197 and
// all-zero key vectors converted to row-major layout.
module tb_aes_key_expander;
    import aes_pkg::*;

    localparam logic [127:0] K1      = 128'h2b28ab097eaef7cf15d2154f16a6883c;
    localparam logic [127:0] K1_RK1  = 128'ha088232afa54a36cfe2c397617b13905;
    localparam logic [127:0] K1_RK2  = 128'hf27a5973c296355995b980f6f2437a7f;
    localparam logic [127:0] K1_RK10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
    localparam logic [127:0] KX      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Z_RK1   = 128'h62626262636363636363636363636363;
    localparam logic [127:0] Z_RK2   = 128'h9bf99bf998fb98fb98fb98fbc9aac9aa;
    localparam logic [127:0] Z_RK10  = 128'hb43e236fef92e98f5be25118cb11cf8e;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    aes_key_expander_if bus ();

    aes_key_expander #(
        .KEY_W      (128),
        .NUM_ROUNDS (10),
        .RK_AW      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input string tag, input logic [3:0] addr, input logic [127:0] exp);
        bus.rk_addr_in = addr;
        tick();
        check(tag, bus.rk_data_out, exp);
    endtask

    // Counts edges until keys_valid_out rises, bounded at 20.
    task automatic wait_kv(input int start, output int n);
        n = start;
        while (!bus.keys_valid_out && n < 20) begin
            tick();
            n++;
        end
    endtask

    logic [3:0]   trk_addr [5];
    logic [127:0] trk_exp  [5];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n            = 1'b0;
        bus.clear_in     = 1'b0;
        bus.key_valid_in = 1'b0;
        bus.key_in       = '0;
        bus.rk_addr_in   = '0;
        #3;
        check("rst_ready", 128'(bus.key_ready_out), 128'd1);
        check("rst_busy", 128'(bus.busy_out), 128'd0);
        check("rst_kv", 128'(bus.keys_valid_out), 128'd0);
        check("rst_data", bus.rk_data_out, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // First key; keep offering a different key throughout EXPAND.
        bus.key_valid_in = 1'b1;
        bus.key_in       = K1;
        tick();
        check("acc_ready", 128'(bus.key_ready_out), 128'd0);
        check("acc_busy", 128'(bus.busy_out), 128'd1);
        check("acc_kv", 128'(bus.keys_valid_out), 128'd0);
        bus.key_in = KX;
        wait_kv(0, cyc);
        bus.key_valid_in = 1'b0;
        check("kv_latency1", 128'(cyc), 128'd10);
        check("ready_busy", 128'(bus.busy_out), 128'd0);
        check("ready_rdy", 128'(bus.key_ready_out), 128'd1);

        read_rk("k1_rk0", 4'd0, K1);
        read_rk("k1_rk1", 4'd1, K1_RK1);
        read_rk("k1_rk2", 4'd2, K1_RK2);
        read_rk("k1_rk10", 4'd10, K1_RK10);
        read_rk("addr11", 4'd11, '0);
        read_rk("addr15", 4'd15, '0);

        // Address changes every cycle; data follows one edge later.
        trk_addr = '{4'd10, 4'd0, 4'd1, 4'd2, 4'd11};
        trk_exp  = '{K1_RK10, K1, K1_RK1, K1_RK2, 128'd0};
        for (int i = 0; i < 5; i++) begin
            read_rk("track", trk_addr[i], trk_exp[i]);
        end

        // All-zero key from READY; rk[0] is overwritten on the accept edge.
        bus.key_valid_in = 1'b1;
        bus.key_in       = '0;
        tick();
        bus.key_valid_in = 1'b0;
        check("z_acc_kv", 128'(bus.keys_valid_out), 128'd0);
        check("z_acc_busy", 128'(bus.busy_out), 128'd1);
        bus.rk_addr_in = 4'd0;
        tick();
        check("z_rk0_early", bus.rk_data_out, '0);
        wait_kv(1, cyc);
        check("kv_latency2", 128'(cyc), 128'd10);
        read_rk("z_rk1", 4'd1, Z_RK1);
        read_rk("z_rk2", 4'd2, Z_RK2);
        read_rk("z_rk10", 4'd10, Z_RK10);

        // Clear at counter 5 (four edges after the accept edge).
        bus.key_valid_in = 1'b1;
        bus.key_in       = K1;
        tick();
        bus.key_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.clear_in = 1'b1;
        tick();
        check("clr_kv", 128'(bus.keys_valid_out), 128'd0);
        check("clr_busy", 128'(bus.busy_out), 128'd0);
        check("clr_ready", 128'(bus.key_ready_out), 128'd1);
        bus.key_valid_in = 1'b1;
        bus.key_in       = KX;
        tick();
        check("clr_acc_busy", 128'(bus.busy_out), 128'd0);
        check("clr_acc_ready", 128'(bus.key_ready_out), 128'd1);
        bus.clear_in     = 1'b0;
        bus.key_valid_in = 1'b0;
        tick();
        check("clr_idle_busy", 128'(bus.busy_out), 128'd0);

        // Asynchronous reset in the middle of an expansion.
        bus.rk_addr_in   = 4'd0;
        bus.key_valid_in = 1'b1;
        bus.key_in       = K1;
        tick();
        bus.key_valid_in = 1'b0;
        tick();
        tick();
        check("pre_rst_data", bus.rk_data_out, K1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 128'(bus.key_ready_out), 128'd1);
        check("arst_busy", 128'(bus.busy_out), 128'd0);
        check("arst_kv", 128'(bus.keys_valid_out), 128'd0);
        check("arst_data", bus.rk_data_out, '0);
        tick();
        rst_n = 1'b1;
        read_rk("arst_rk1", 4'd1, '0);
        read_rk("arst_rk0", 4'd0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequences the combinational `aes_key_schedule` block over rounds 1..10 to expand one 128-bit AES cipher key into 11 round keys.
- Stores the round keys in an internal register file and serves them through an indexed read port to the AES round datapath.
- Accepts a new key over a valid/ready handshake and flags when the full key set is valid.
- Key and round-key byte layout is the state-matrix row-major form already used by `aes_key_schedule`: bits [127:96] are row 0, bytes in column order.

Parameters:
- KEY_W, 128, key and round-key width; only 128 is supported.
- NUM_ROUNDS, 10, number of expansion rounds; only 10 is supported.
- RK_AW, 4, round-key address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear_in  input  1  synchronous clear; invalidates stored keys and returns to IDLE.
- key_valid_in  input  1  cipher key offered.
- key_ready_out  output  1  expander can accept a key.
- key_in  input  KEY_W  cipher key in row-major matrix layout.
- busy_out  output  1  expansion in progress.
- keys_valid_out  output  1  all 11 round keys valid.
- rk_addr_in  input  RK_AW  round-key index, 0..10.
- rk_data_out  output  KEY_W  registered round-key read data.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Reset values:
  - State = IDLE, round counter = 0.
  - key_ready_out = 1, busy_out = 0, keys_valid_out = 0, rk_data_out = 0.
  - Register file cleared to 0.
- States: IDLE, EXPAND, READY.
- Handshake: a key is accepted on an edge where key_valid_in && key_ready_out.
  - key_ready_out = 1 in IDLE and READY, 0 in EXPAND.
  - key_in need only be stable in the accept cycle.
- Accept edge E0:
  - rk[0] <= key_in; working register <= key_in; round counter <= 1.
  - State -> EXPAND, keys_valid_out <= 0.
- EXPAND, edges E1..E10:
  - `aes_key_schedule` is driven with round_in = counter and key_in = working register.
  - key_out is written to rk[counter] and to the working register; counter increments.
  - On E10 (counter == NUM_ROUNDS): state -> READY, counter -> 0, keys_valid_out <= 1.
  - keys_valid_out is therefore visible in the cycle after E10, which is 10 cycles after E0.
- busy_out = 1 exactly while in EXPAND.
- READY:
  - Holds keys indefinitely.
  - A new accept re-enters EXPAND. keys_valid_out drops on that accept edge, and rk[0] is overwritten immediately.
- clear_in:
  - From any state, next state = IDLE, counter = 0, keys_valid_out = 0.
  - Register contents are not cleared.
  - clear_in has priority over a simultaneous accept; the key is not taken and key_ready_out stays 1.
- Reset mid-EXPAND: everything returns to reset values at once. No partial keys are valid.
- Read port:
  - rk_data_out <= rk[rk_addr_in] every edge, so read latency is 1 cycle.
  - Address 11..15 returns 0.
  - A read during EXPAND returns current register contents, which may be stale or partial; consumers must gate on keys_valid_out.
  - Read and write of the same entry on the same edge returns the old value (no bypass).
- Width rules: the counter is RK_AW bits and never exceeds NUM_ROUNDS.

Decomposition:
- Shared package `aes_pkg`:
  - AES_KEY_W = 128, AES_NUM_ROUNDS = 10, AES_RK_AW = 4.
  - typedef `aes_block_t` (logic [127:0]).
  - enum `key_exp_state_t` {IDLE, EXPAND, READY}.
- Sub-module: instantiate the existing `aes_key_schedule` (round_in, key_in, key_out) unchanged.
- The register file stays inline; no further sub-modules.

Test Plan:
- Reset, then offer key_in = 128'h2b28ab097eaef7cf15d2154f16a6883c:
  - key_ready_out = 0 and busy_out = 1 after the accept edge.
  - keys_valid_out rises exactly 10 cycles after accept.
  - rk_addr_in = 1 reads 128'ha088232afa54a36cfe2c397617b13905.
  - rk_addr_in = 10 reads 128'hd0c9e1b614ee3f63f9250c0ca889c8a6.
  - rk_addr_in = 0 reads the cipher key.
- Hold key_valid_in high during EXPAND with a different key -> not accepted; final round keys match the first key.
- In READY, accept the all-zero key:
  - keys_valid_out drops on that edge and rises 10 cycles later.
  - rk[1] = 128'h62626262636363636363636363636363.
- Assert clear_in at counter = 5:
  - Next cycle IDLE, keys_valid_out = 0, busy_out = 0, key_ready_out = 1.
  - Assert clear_in together with key_valid_in: key not accepted.
- Drop rst_n asynchronously mid-EXPAND, off a clock edge -> all outputs at reset values immediately; rk_data_out = 0.
- rk_addr_in = 11 and 15 in READY -> rk_data_out = 0 one cycle later.
- Change rk_addr_in every cycle -> data tracks the address with exactly 1-cycle latency.
